encoder_8b10b: RTL

//  TX-side 8b/10b encoder: mirror of the RX decoder. Takes a byte plus a K flag each

---
 rtl/encoder_8b10b_if.sv | 21 ++
 rtl/encoder_8b10b.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/encoder_8b10b_if.sv
// Parallel TX bus between the datapath and the 8b/10b encoder.
// The master drives the byte side and the slave (encoder) drives the code-group side.
interface encoder_8b10b_if;
    logic [7:0] TxParallel_8;
    logic       TxDataK;
    logic       TxValid;
    logic [9:0] TxParallel_10;
    logic       TxValid_10;
    logic       TxCodeErr;
    logic       TxRD;

    modport master (
        output TxParallel_8, TxDataK, TxValid,
        input  TxParallel_10, TxValid_10, TxCodeErr, TxRD
    );

    modport slave (
        input  TxParallel_8, TxDataK, TxValid,
        output TxParallel_10, TxValid_10, TxCodeErr, TxRD
    );
endinterface

// File: rtl/encoder_8b10b.sv
// TX 8b/10b encoder: one byte/K per cycle to a DC-balanced 10-bit code group,
// with idle comma insertion, illegal-K substitution and a running disparity register.
module encoder_8b10b #(
    parameter logic [7:0] IDLE_CHAR = 8'hBC,
    parameter logic       RD_INIT   = 1'b0
) (
    input  logic           BitCLK_10,
    input  logic           Reset,
    encoder_8b10b_if.slave tx
);
    localparam int unsigned SYM_W = 10;
    localparam int unsigned X_W   = 5;
    localparam int unsigned Y_W   = 3;

    // RD- form of the 5b/6b table, returned as {a,b,c,d,e,i}
    function automatic logic [5:0] enc6_rdm(input logic [X_W-1:0] x);
        logic [5:0] r;
        case (x)
            5'd0:    r = 6'b100111;
            5'd1:    r = 6'b011101;
            5'd2:    r = 6'b101101;
            5'd3:    r = 6'b110001;
            5'd4:    r = 6'b110101;
            5'd5:    r = 6'b101001;
            5'd6:    r = 6'b011001;
            5'd7:    r = 6'b111000;
            5'd8:    r = 6'b111001;
            5'd9:    r = 6'b100101;
            5'd10:   r = 6'b010101;
            5'd11:   r = 6'b110100;
            5'd12:   r = 6'b001101;
            5'd13:   r = 6'b101100;
            5'd14:   r = 6'b011100;
            5'd15:   r = 6'b010111;
            5'd16:   r = 6'b011011;
            5'd17:   r = 6'b100011;
            5'd18:   r = 6'b010011;
            5'd19:   r = 6'b110010;
            5'd20:   r = 6'b001011;
            5'd21:   r = 6'b101010;
            5'd22:   r = 6'b011010;
            5'd23:   r = 6'b111010;
            5'd24:   r = 6'b110011;
            5'd25:   r = 6'b100110;
            5'd26:   r = 6'b010110;
            5'd27:   r = 6'b110110;
            5'd28:   r = 6'b001110;
            5'd29:   r = 6'b101110;
            5'd30:   r = 6'b011110;
            default: r = 6'b101011;
        endcase
        return r;
    endfunction

    // RD- form of the 3b/4b table, returned as {f,g,h,j}; y=7 gives P7
    function automatic logic [3:0] enc4_rdm(input logic [Y_W-1:0] y);
        logic [3:0] r;
        case (y)
            3'd0:    r = 4'b1011;
            3'd1:    r = 4'b1001;
            3'd2:    r = 4'b0101;
            3'd3:    r = 4'b1100;
            3'd4:    r = 4'b1101;
            3'd5:    r = 4'b1010;
            3'd6:    r = 4'b0110;
            default: r = 4'b1110;
        endcase
        return r;
    endfunction

    logic [SYM_W-1:0] tx10_q, tx10_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             rd_q, rd_d;

    logic             k_sel;
    logic [7:0]       byte_sel;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             legal_k;
    logic             use_a7;
    logic             rd_mid;
    logic [5:0]       code6;
    logic [3:0]       code4;

    always_comb begin
        k_sel    = 1'b1;
        byte_sel = IDLE_CHAR;
        err_d    = 1'b0;
        valid_d  = 1'b1;

        if (tx.TxValid) begin
            k_sel    = tx.TxDataK;
            byte_sel = tx.TxParallel_8;
        end

        x       = byte_sel[X_W-1:0];
        y       = byte_sel[7:X_W];
        legal_k = (x == 5'd28) ||
                  ((y == 3'd7) && (x inside {5'd23, 5'd27, 5'd29, 5'd30}));

        // Unsupported K: send the idle character and flag it for one cycle
        if (tx.TxValid && k_sel && !legal_k) begin
            err_d    = 1'b1;
            k_sel    = 1'b1;
            byte_sel = IDLE_CHAR;
            x        = byte_sel[X_W-1:0];
            y        = byte_sel[7:X_W];
        end

        // 6b sub-block: unbalanced codes and D.7 mirror at RD+
        code6 = (k_sel && (x == 5'd28)) ? 6'b001111 : enc6_rdm(x);
        if (rd_q && (($countones(code6) != 3) || (x == 5'd7))) begin
            code6 = ~code6;
        end
        rd_mid = ($countones(code6) == 3) ? rd_q : ~rd_q;

        // 4b sub-block: A7 avoids a run of five across the e/i-f/g/h boundary
        use_a7 = (y == 3'd7) &&
                 (k_sel ||
                  (!rd_mid && (x inside {5'd17, 5'd18, 5'd20})) ||
                  ( rd_mid && (x inside {5'd11, 5'd13, 5'd14})));
        code4 = use_a7 ? 4'b0111 : enc4_rdm(y);
        if (rd_mid && (($countones(code4) != 2) || (y == 3'd3))) begin
            code4 = ~code4;
        end
        if (k_sel && (x == 5'd28) && !rd_mid && (y inside {3'd1, 3'd2, 3'd5, 3'd6})) begin
            code4 = ~code4;
        end
        rd_d = ($countones(code4) == 2) ? rd_mid : ~rd_mid;

        // Port order is a at bit 0 through j at bit 9
        tx10_d = {code4[0], code4[1], code4[2], code4[3],
                  code6[0], code6[1], code6[2], code6[3], code6[4], code6[5]};
    end

    always_ff @(posedge BitCLK_10) begin
        if (Reset) begin
            tx10_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= RD_INIT;
        end else begin
            tx10_q  <= tx10_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign tx.TxParallel_10 = tx10_q;
    assign tx.TxValid_10    = valid_q;
    assign tx.TxCodeErr     = err_q;
    assign tx.TxRD          = rd_q;
endmodule
